// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates the active-low row drive, synchronises the columns and
// debounces whole scan frames into a 5-bit key code (16 = no key) with a one-cycle new-key pulse.
module keypad_scanner #(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [4:0] key,
  output logic       key_new,
  output logic [1:0] dbg_state
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEB_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_SCANS);
  localparam logic [4:0]        KEY_NONE  = 5'd16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_HELD    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'd1;
      4'h1:    k = 4'd2;
      4'h2:    k = 4'd3;
      4'h3:    k = 4'd10;
      4'h4:    k = 4'd4;
      4'h5:    k = 4'd5;
      4'h6:    k = 4'd6;
      4'h7:    k = 4'd11;
      4'h8:    k = 4'd7;
      4'h9:    k = 4'd8;
      4'hA:    k = 4'd9;
      4'hB:    k = 4'd12;
      4'hC:    k = 4'd14;
      4'hD:    k = 4'd0;
      4'hE:    k = 4'd15;
      default: k = 4'd13;
    endcase
    return k;
  endfunction

  logic [3:0]        col_s1_q, col_s2_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [3:0]        acc_key_q, acc_key_d;

  state_e            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        key_q, key_d;
  logic              key_new_q, key_new_d;

  logic       slot_end, frame_end;
  logic [3:0] col_low;
  logic [2:0] slot_lows, frame_lows;
  logic [1:0] col_idx;
  logic [3:0] slot_key, frame_key;
  logic       frame_none, frame_single;

  // Column sampling and per-frame low-bit accumulation; the accumulator saturates at 2 (MULTI).
  always_comb begin
    slot_end  = (slot_q == SLOT_LAST);
    frame_end = slot_end && (row_idx_q == 2'd3);
    col_low   = ~col_s2_q;
    slot_lows = 3'($countones(col_low));
    case (col_low)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    slot_key     = key_map(row_idx_q, col_idx);
    frame_lows   = {1'b0, acc_cnt_q} + slot_lows;
    frame_key    = (acc_cnt_q == 2'd0) ? slot_key : acc_key_q;
    frame_none   = (frame_lows == 3'd0);
    frame_single = (frame_lows == 3'd1);

    slot_d    = slot_end ? '0 : slot_q + SLOT_W'(1);
    row_idx_d = slot_end ? row_idx_q + 2'd1 : row_idx_q;
    acc_cnt_d = acc_cnt_q;
    acc_key_d = acc_key_q;
    if (frame_end) begin
      acc_cnt_d = 2'd0;
      acc_key_d = 4'd0;
    end else if (slot_end) begin
      acc_cnt_d = (frame_lows >= 3'd2) ? 2'd2 : frame_lows[1:0];
      acc_key_d = frame_key;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1_q  <= 4'b1111;
      col_s2_q  <= 4'b1111;
      slot_q    <= '0;
      row_idx_q <= 2'd0;
      acc_cnt_q <= 2'd0;
      acc_key_q <= 4'd0;
    end else begin
      col_s1_q  <= col;
      col_s2_q  <= col_s1_q;
      slot_q    <= slot_d;
      row_idx_q <= row_idx_d;
      acc_cnt_q <= acc_cnt_d;
      acc_key_q <= acc_key_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cand_q    <= 4'd0;
      cnt_q     <= '0;
      key_q     <= KEY_NONE;
      key_new_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      key_new_q <= key_new_d;
    end
  end

  // Debounce advances only on frame_end; a held key is never replaced until a full release.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    key_new_d = 1'b0;
    if (frame_end) begin
      case (state_q)
        S_IDLE: begin
          if (frame_single) begin
            cand_d = frame_key;
            cnt_d  = DEB_W'(1);
            if (DEB_SCANS == 1) begin
              state_d   = S_HELD;
              key_d     = {1'b0, frame_key};
              key_new_d = 1'b1;
            end else begin
              state_d = S_PRESS;
            end
          end
        end
        S_PRESS: begin
          if (frame_single && (frame_key == cand_q)) begin
            cnt_d = cnt_q + DEB_W'(1);
            if (cnt_d == DEB_MAX) begin
              state_d   = S_HELD;
              key_d     = {1'b0, cand_q};
              key_new_d = 1'b1;
            end
          end else if (frame_single) begin
            cand_d = frame_key;
            cnt_d  = DEB_W'(1);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_HELD: begin
          if (frame_none) begin
            if (DEB_SCANS == 1) begin
              state_d = S_IDLE;
              key_d   = KEY_NONE;
              cnt_d   = '0;
            end else begin
              state_d = S_RELEASE;
              cnt_d   = DEB_W'(1);
            end
          end else if (frame_single && ({1'b0, frame_key} == key_q)) begin
            cnt_d = '0;
          end
        end
        S_RELEASE: begin
          if (frame_none) begin
            cnt_d = cnt_q + DEB_W'(1);
            if (cnt_d == DEB_MAX) begin
              state_d = S_IDLE;
              key_d   = KEY_NONE;
              cnt_d   = '0;
            end
          end else begin
            state_d = S_HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    row            = 4'b1111;
    row[row_idx_q] = 1'b0;
    key            = key_q;
    key_new        = key_new_q;
    dbg_state      = state_q;
  end

endmodule
